// File: rtl/req_arbiter10.sv
// req_arbiter10: ten-requester arbiter with fixed-priority or round-robin selection.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   en_i         arbiter enable; low blocks new grants and forces release of the owner
//   mode_sel_i   0 = fixed priority (req_i[9] highest), 1 = round-robin from rr_ptr
//   req_i[9:0]   request vector, held high while a requester needs the resource
//   gnt_o[9:0]   registered one-hot grant
//   gnt_id_o     BCD index (0-9) of the owner, 0 when no owner
//   gnt_vld_o    high while a grant is active
//   timeout_o    one-cycle pulse on a forced (hold-limit) release
//
// Parameter MAX_HOLD (2..255) bounds the cycles one owner may hold the grant.
// Optional feature macro: ARB_TIMEOUT_EN enables the MAX_HOLD limit and the
// timeout pulse; without it a grant lasts until req drops or en_i goes low.
module req_arbiter10 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       mode_sel_i,
   input  logic [9:0] req_i,
   output logic [9:0] gnt_o,
   output logic [3:0] gnt_id_o,
   output logic       gnt_vld_o,
   output logic       timeout_o
);
   typedef enum logic [1:0] {IDLE, GRANT, REL} state_t;
   state_t     state_q, state_d;
   logic [9:0] gnt_q, gnt_d;
   logic [3:0] gnt_id_q, gnt_id_d;
   logic       gnt_vld_q, gnt_vld_d;
   logic       timeout_q, timeout_d;
   logic [3:0] rr_ptr_q, rr_ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [9:0] req_rot;
   logic [3:0] fp_win, rr_off, win;
   logic [4:0] rr_sum;
   logic       arb_go, own_req, hold_hit, rel_go;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("req_arbiter10: MAX_HOLD must be within 2..255");
   end

`ifdef ARB_TIMEOUT_EN
   assign hold_hit = hold_cnt_q == 8'(MAX_HOLD - 1);
`else
   assign hold_hit = 1'b0;
`endif

   assign arb_go  = en_i && |req_i;
   assign own_req = |(req_i & gnt_q);
   assign rel_go  = !own_req || !en_i || hold_hit;

   // Round-robin: rotate the request vector so rr_ptr sits at bit 0, take the
   // lowest set bit, then add the pointer back modulo 10.
   always_comb begin
      fp_win = '0;
      for (int i = 0; i < 10; i++) if (req_i[i]) fp_win = 4'(i);
      req_rot = 10'({req_i, req_i} >> rr_ptr_q);
      rr_off = '0;
      for (int i = 9; i >= 0; i--) if (req_rot[i]) rr_off = 4'(i);
      rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
      win = mode_sel_i ? ((rr_sum > 5'd9) ? 4'(rr_sum - 5'd10) : rr_sum[3:0]) : fp_win;
   end

   // REL arbitrates exactly like IDLE, so only one dead cycle separates owners.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, REL: state_d = arb_go ? GRANT : IDLE;
         GRANT:     state_d = rel_go ? REL : GRANT;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d      = '0;
      gnt_id_d   = '0;
      gnt_vld_d  = 1'b0;
      timeout_d  = 1'b0;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      if (state_q != GRANT && state_d == GRANT) begin
         gnt_d      = 10'b1 << win;
         gnt_id_d   = win;
         gnt_vld_d  = 1'b1;
         hold_cnt_d = '0;
         if (mode_sel_i) rr_ptr_d = (win == 4'd9) ? 4'd0 : win + 4'd1;
      end else if (state_q == GRANT && state_d == GRANT) begin
         gnt_d      = gnt_q;
         gnt_id_d   = gnt_id_q;
         gnt_vld_d  = 1'b1;
         hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
      end else if (state_q == GRANT) begin
         // A hold-limit hit only counts as a timeout when nothing else released the owner.
         timeout_d = own_req && en_i && hold_hit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         gnt_vld_q  <= 1'b0;
         timeout_q  <= 1'b0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         gnt_vld_q  <= gnt_vld_d;
         timeout_q  <= timeout_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign gnt_id_o  = gnt_id_q;
   assign gnt_vld_o = gnt_vld_q;
   assign timeout_o = timeout_q;
endmodule

// File: tb/tb_req_arbiter10.sv
// tb_req_arbiter10: scoreboard bench for req_arbiter10 (default and ARB_TIMEOUT_EN builds).
module tb_req_arbiter10;
   logic       clk = 1'b0;
   logic       rst_n, en, mode_sel;
   logic [9:0] req;
   logic [9:0] gnt;
   logic [3:0] gnt_id;
   logic       gnt_vld, timeout;
   int         total = 0;
   int         bad = 0;

   typedef struct packed {logic en; logic m; logic [9:0] rq; logic vld; logic [3:0] id; logic to;} row_t;
   typedef struct packed {logic vld; logic [3:0] id; logic to;} exp_t;
   exp_t sb[$];

   req_arbiter10 #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .mode_sel_i(mode_sel), .req_i(req),
      .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_vld_o(gnt_vld), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      exp_t e;
      logic [9:0] eg;
      rst_n = 1'b0; en = 1'b0; mode_sel = 1'b0; req = '0;
      #1;
      total++;
      if ({gnt, gnt_id, gnt_vld, timeout} !== 16'h0) begin
         bad++;
         $display("FAIL reset: got gnt=%b id=%0d vld=%b to=%b, want all zero", gnt, gnt_id, gnt_vld, timeout);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; en = 1'b1; req = '0;
      sb.push_back('{1'b0, 4'd0, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.vld ? 10'b1 << e.id : 10'b0;
      total++;
      if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
         bad++;
         $display("FAIL idle_no_req: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
      end
   endtask

   task automatic test_fixed;
      row_t rows [6];
      exp_t e;
      logic [9:0] eg;
      rows = '{'{1'b1, 1'b0, 10'h204, 1'b1, 4'd9, 1'b0},
               '{1'b1, 1'b0, 10'h004, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b0, 10'h004, 1'b1, 4'd2, 1'b0},
               '{1'b1, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0}};
      foreach (rows[i]) begin
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL fixed row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   task automatic test_round_robin;
      row_t rows[$];
      exp_t e;
      logic [9:0] eg, mask;
      for (int k = 0; k <= 10; k++) begin
         mask = 10'h3FF & ~(10'b1 << (k % 10));
         rows.push_back('{1'b1, 1'b1, 10'h3FF, 1'b1, 4'(k % 10), 1'b0});
         rows.push_back('{1'b1, 1'b1, 10'h3FF, 1'b1, 4'(k % 10), 1'b0});
         rows.push_back('{1'b1, 1'b1, 10'h3FF, 1'b1, 4'(k % 10), 1'b0});
         rows.push_back('{1'b1, 1'b1, mask, 1'b0, 4'd0, 1'b0});
      end
      rows.push_back('{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0});
      foreach (rows[i]) begin
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL round_robin row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   task automatic test_en_drop;
      row_t rows [6];
      exp_t e;
      logic [9:0] eg;
      rows = '{'{1'b1, 1'b0, 10'h020, 1'b1, 4'd5, 1'b0},
               '{1'b0, 1'b0, 10'h020, 1'b0, 4'd0, 1'b0},
               '{1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0},
               '{1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0},
               '{1'b0, 1'b0, 10'h3FF, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0}};
      foreach (rows[i]) begin
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL en_drop row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   task automatic test_no_preempt;
      row_t rows [7];
      exp_t e;
      logic [9:0] eg;
      rows = '{'{1'b1, 1'b0, 10'h010, 1'b1, 4'd4, 1'b0},
               '{1'b1, 1'b0, 10'h090, 1'b1, 4'd4, 1'b0},
               '{1'b1, 1'b1, 10'h090, 1'b1, 4'd4, 1'b0},
               '{1'b1, 1'b0, 10'h080, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b0, 10'h080, 1'b1, 4'd7, 1'b0},
               '{1'b1, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b0, 10'h000, 1'b0, 4'd0, 1'b0}};
      foreach (rows[i]) begin
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL no_preempt row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   // rr_ptr enters this test at 1 (last round-robin grant was owner 0).
   task automatic test_rr_boundary;
      row_t rows [9];
      exp_t e;
      logic [9:0] eg;
      rows = '{'{1'b1, 1'b1, 10'h001, 1'b1, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h202, 1'b1, 4'd1, 1'b0},
               '{1'b1, 1'b1, 10'h200, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h203, 1'b1, 4'd9, 1'b0},
               '{1'b1, 1'b1, 10'h003, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0}};
      foreach (rows[i]) begin
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL rr_boundary row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   task automatic test_timeout;
      row_t rows [14];
      exp_t e;
      logic [9:0] eg;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
      rows[0:7] = '{'{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b0, 4'd0, 1'b1},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd1, 1'b0},
                    '{1'b1, 1'b1, 10'h001, 1'b0, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0}};
`else
      rows[0:7] = '{'{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h003, 1'b1, 4'd0, 1'b0},
                    '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0}};
`endif
      // Owner drops req exactly when the hold limit would fire: plain release.
      rows[8:13] = '{'{1'b1, 1'b1, 10'h001, 1'b1, 4'd0, 1'b0},
                     '{1'b1, 1'b1, 10'h001, 1'b1, 4'd0, 1'b0},
                     '{1'b1, 1'b1, 10'h001, 1'b1, 4'd0, 1'b0},
                     '{1'b1, 1'b1, 10'h001, 1'b1, 4'd0, 1'b0},
                     '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0},
                     '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0}};
      foreach (rows[i]) begin
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL timeout row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   task automatic test_reset_mid_grant;
      row_t rows [4];
      exp_t e;
      logic [9:0] eg;
      rows = '{'{1'b1, 1'b0, 10'h3FF, 1'b1, 4'd9, 1'b0},
               '{1'b1, 1'b1, 10'h3FF, 1'b1, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0},
               '{1'b1, 1'b1, 10'h000, 1'b0, 4'd0, 1'b0}};
      foreach (rows[i]) begin
         if (i == 1) begin
            #2;
            rst_n = 1'b0;
            #1;
            total++;
            if ({gnt, gnt_id, gnt_vld, timeout} !== 16'h0) begin
               bad++;
               $display("FAIL async_reset: got gnt=%b id=%0d vld=%b to=%b, want all zero", gnt, gnt_id, gnt_vld, timeout);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         en = rows[i].en; mode_sel = rows[i].m; req = rows[i].rq;
         sb.push_back('{rows[i].vld, rows[i].id, rows[i].to});
         @(posedge clk); #1;
         e = sb.pop_front();
         eg = e.vld ? 10'b1 << e.id : 10'b0;
         total++;
         if ({gnt, gnt_id, gnt_vld, timeout} !== {eg, e.id, e.vld, e.to}) begin
            bad++;
            $display("FAIL reset_mid row %0d: got gnt=%b id=%0d vld=%b to=%b, want gnt=%b id=%0d vld=%b to=%b", i, gnt, gnt_id, gnt_vld, timeout, eg, e.id, e.vld, e.to);
         end
      end
   endtask

   initial begin
      test_reset;
      test_fixed;
      test_round_robin;
      test_en_drop;
      test_no_preempt;
      test_rr_boundary;
      test_timeout;
      test_reset_mid_grant;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/req_arbiter10.md
Name: req_arbiter10

Overview:
- Ten-requester arbiter that shares one resource using BCD-encoder priority rules.
- Fixed-priority mode: req[9] is highest.
- Round-robin mode: search rotates from a pointer.
- Outputs a registered one-hot grant and its 4-bit BCD index (0-9), for the datapath or shared-resource mux.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant (used only with ARB_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  arbiter enable; 0 means no new grants and forces release of the current grant.
- mode_sel  input  1  0 = fixed priority, 1 = round-robin; sampled only when arbitrating.
- req  input  10  request vector; a requester holds req high for as long as it needs the resource.
- gnt  output  10  registered one-hot grant; all zero when no owner.
- gnt_id  output  4  BCD index of the owner, 0-9; 0 when gnt_vld = 0.
- gnt_vld  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; gnt = 0, gnt_id = 0, gnt_vld = 0, timeout = 0.
  - rr_ptr = 0, hold_cnt = 0.
- States: IDLE, GRANT, REL.
- IDLE:
  - If en = 1 and req != 0, pick a winner, register gnt / gnt_id / gnt_vld, then go to GRANT.
  - Latency is 1 cycle from req sampled to gnt high.
  - Otherwise stay in IDLE with outputs at 0.
- Fixed-priority pick: highest set bit wins (9 > 8 > ... > 0).
- Round-robin pick: first set bit scanning rr_ptr, rr_ptr+1, ..., 9, 0, ..., rr_ptr-1 (mod 10).
  - On each grant, rr_ptr = winner+1; winner 9 wraps rr_ptr to 0.
  - rr_ptr is updated only in round-robin mode; fixed-priority grants leave rr_ptr unchanged.
- GRANT:
  - Outputs are held stable.
  - Leave to REL when req[gnt_id] = 0, or en = 0, or timeout fires.
  - Requests from other requesters are ignored; there is no preemption.
  - Changes on mode_sel have no effect until the next IDLE arbitration.
- REL:
  - Exactly one cycle with gnt = 0, gnt_vld = 0, gnt_id = 0, then return to IDLE.
  - Guarantees one dead cycle between owners.
  - Back-to-back: next grant is asserted 2 cycles after the release condition is seen.
- hold_cnt:
  - 8-bit; cleared on entry to GRANT; increments each GRANT cycle; saturates at 255.
- Simultaneous events:
  - Owner drops req in the same cycle timeout would fire: normal release, timeout stays 0.
  - en = 0 in the same cycle as owner release: normal release, same REL behaviour.
- Boundary conditions:
  - req = 0 in IDLE: no grant.
  - Single requester: that requester wins in both modes.
  - In round-robin mode, a requester whose bit equals rr_ptr wins over all others.
- Reset mid-GRANT: outputs clear immediately (async); rr_ptr returns to 0.
- No internal combinational path from req to gnt; all outputs are flops.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt reaches MAX_HOLD-1 while still in GRANT, go to REL and pulse timeout for that REL cycle.
  - In round-robin mode rr_ptr already points past the offender, so a persistent requester cannot starve others.
  - In fixed-priority mode the same requester may win again after REL.
- Undefined:
  - No hold_cnt limit; a grant lasts until req drops or en = 0.
  - timeout is tied to 0.

Test Plan:
- Reset then fixed mode, en = 1, req = 10'b10_0000_0100 → next cycle gnt = 10'b10_0000_0000, gnt_id = 9, gnt_vld = 1; drop req[9] → one REL cycle with gnt = 0, then gnt_id = 2.
- Round-robin mode, req = 10'h3FF held, each owner drops req for 1 cycle after a 3-cycle hold → grant order 0, 1, 2, ..., 9, 0 with one dead cycle between grants; rr_ptr wraps 9 → 0.
- en = 0 during GRANT (owner 5) → REL next cycle, gnt = 0; with en held 0 and req != 0, no new grant occurs.
- Owner 4 holding, req[7] asserted in fixed mode → gnt stays on 4 (no preemption); after req[4] drops, gnt_id = 7 two cycles later.
- ARB_TIMEOUT_EN with MAX_HOLD = 4, round-robin, req = 10'b00_0000_0011 held → owner 0 released after 4 GRANT cycles with a timeout pulse, then owner 1 granted; without the macro, owner 0 is held indefinitely and timeout = 0.
- Assert rst_n = 0 asynchronously mid-GRANT → gnt, gnt_id, gnt_vld and timeout are 0 immediately; after release, round-robin with req = 10'h3FF grants 0 first.
